// File: rtl/cfg_reg_arbiter.sv
// Round-robin write arbiter for the shared 5-entry configuration bank (ports A and B).
// Define CFG_SHADOW_EN to stage writes in shadow registers that commit on commit_strobe.
module cfg_reg_arbiter #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic              m_clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_gnt,
  input  logic              commit_strobe,
  output logic              err_addr,
  output logic              pending,
  output logic [DATA_W-1:0] reg_0,
  output logic [DATA_W-1:0] reg_1,
  output logic [DATA_W-1:0] reg_2,
  output logic [DATA_W-1:0] reg_3,
  output logic [DATA_W-1:0] reg_4
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {IDLE, GRANT} state_t;
  typedef enum logic {WIN_A, WIN_B} winner_t;

  state_t              state_q, state_d;
  winner_t             lastWinner_q, lastWinner_d;
  logic                aGnt_q, aGnt_d;
  logic                bGnt_q, bGnt_d;
  logic                errAddr_q, errAddr_d;
  logic                wrEn;
  logic [ADDR_W-1:0]   wrAddr;
  logic [DATA_W-1:0]   wrData;
  logic                wrInRange;
  logic [IDX_W-1:0]    wrIdx;
  logic [NUM_REGS-1:0] writeMask;
  logic [DATA_W-1:0]   active_q [NUM_REGS];

  // A wins a contest unless it was the last winner; GRANT is a dead cycle so each requester can drop req.
  always_comb begin
    state_d      = state_q;
    lastWinner_d = lastWinner_q;
    aGnt_d       = 1'b0;
    bGnt_d       = 1'b0;
    errAddr_d    = 1'b0;
    wrEn         = 1'b0;
    wrAddr       = a_addr;
    wrData       = a_data;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          if (a_req && (!b_req || (lastWinner_q == WIN_B))) begin
            aGnt_d       = 1'b1;
            lastWinner_d = WIN_A;
            wrAddr       = a_addr;
            wrData       = a_data;
          end else begin
            bGnt_d       = 1'b1;
            lastWinner_d = WIN_B;
            wrAddr       = b_addr;
            wrData       = b_data;
          end
          wrEn      = 1'b1;
          errAddr_d = (wrAddr >= ADDR_W'(NUM_REGS));
          state_d   = GRANT;
        end
      end
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lastWinner_q <= WIN_B;
      aGnt_q       <= 1'b0;
      bGnt_q       <= 1'b0;
      errAddr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lastWinner_q <= lastWinner_d;
      aGnt_q       <= aGnt_d;
      bGnt_q       <= bGnt_d;
      errAddr_q    <= errAddr_d;
    end
  end

  // The range check uses the full address; only then do the low bits select an entry.
  assign wrInRange = (wrAddr < ADDR_W'(NUM_REGS));
  assign wrIdx     = wrAddr[IDX_W-1:0];

  always_comb begin
    writeMask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      writeMask[i] = wrEn && wrInRange && (wrIdx == IDX_W'(i));
    end
  end

`ifdef CFG_SHADOW_EN
  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [NUM_REGS-1:0] commitMask;
  logic                pending_q;

  // A write landing on a commit edge stays dirty; its new value goes out on the next strobe.
  assign commitMask = commit_strobe ? dirty_q : '0;
  assign dirty_d    = (dirty_q & ~commitMask) | writeMask;

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      dirty_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (writeMask[i]) shadow_q[i] <= wrData;
        if (commitMask[i]) active_q[i] <= shadow_q[i];
      end
      dirty_q   <= dirty_d;
      pending_q <= |dirty_d;
    end
  end

  assign pending = pending_q;
`else
  logic unused_commit;
  assign unused_commit = commit_strobe;

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (writeMask[i]) active_q[i] <= wrData;
      end
    end
  end

  assign pending = 1'b0;
`endif

  assign a_gnt    = aGnt_q;
  assign b_gnt    = bGnt_q;
  assign err_addr = errAddr_q;
  assign reg_0    = active_q[0];
  assign reg_1    = active_q[1];
  assign reg_2    = active_q[2];
  assign reg_3    = active_q[3];
  assign reg_4    = active_q[4];

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Directed vector bench for cfg_reg_arbiter; expectations follow whichever build (CFG_SHADOW_EN or not) is compiled.
module tb_cfg_reg_arbiter;

`ifdef CFG_SHADOW_EN
  localparam bit S = 1'b1;
`else
  localparam bit S = 1'b0;
`endif

  logic       m_clk = 1'b0;
  logic       rst_n;
  logic       a_req, b_req, commit_strobe;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_gnt, b_gnt, err_addr, pending;
  logic [7:0] reg_0, reg_1, reg_2, reg_3, reg_4;
  logic [43:0] actual;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       aReq;
    logic [6:0] aAddr;
    logic [7:0] aData;
    logic       bReq;
    logic [6:0] bAddr;
    logic [7:0] bData;
    logic       commit;
    logic [43:0] expOut;
  } vec_t;

  vec_t vecs[$];

  cfg_reg_arbiter dut (
    .m_clk(m_clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
    .commit_strobe(commit_strobe), .err_addr(err_addr), .pending(pending),
    .reg_0(reg_0), .reg_1(reg_1), .reg_2(reg_2), .reg_3(reg_3), .reg_4(reg_4)
  );

  always #5 m_clk = ~m_clk;

  assign actual = {a_gnt, b_gnt, err_addr, pending, reg_0, reg_1, reg_2, reg_3, reg_4};

  function automatic logic [43:0] mk(input logic ag, input logic bg, input logic er, input logic pd,
                                     input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                                     input logic [7:0] r3, input logic [7:0] r4);
    return {ag, bg, er, pd, r0, r1, r2, r3, r4};
  endfunction

  task automatic addVec(input logic ar, input logic [6:0] aa, input logic [7:0] ad,
                        input logic br, input logic [6:0] ba, input logic [7:0] bd,
                        input logic cm, input logic [43:0] ex);
    vec_t v;
    v.aReq = ar; v.aAddr = aa; v.aData = ad;
    v.bReq = br; v.bAddr = ba; v.bData = bd;
    v.commit = cm; v.expOut = ex;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    a_req = v.aReq; a_addr = v.aAddr; a_data = v.aData;
    b_req = v.bReq; b_addr = v.bAddr; b_data = v.bData;
    commit_strobe = v.commit;
    @(posedge m_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [43:0] exp);
    checks++;
    if (actual !== exp) begin
      errors++;
      $display("[TB] FAIL %s got {gA,gB,err,pend,r0..r4}=%h exp %h", name, actual, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got timeout exp finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Every vector is one clock; expected outputs are sampled 1 ns after the edge.
    addVec(1, 2, 8'h5A, 0, 0, 0, 0, mk(1,0,0,S, 0,0, S ? 8'h00 : 8'h5A, 0,0));
    addVec(0, 0, 0,     0, 0, 0, 0, mk(0,0,0,S, 0,0, S ? 8'h00 : 8'h5A, 0,0));
    addVec(0, 0, 0,     0, 0, 0, 1, mk(0,0,0,0, 0,0, 8'h5A, 0,0));
    addVec(0, 0, 0,     1, 7, 8'hFF, 0, mk(0,1,1,0, 0,0, 8'h5A, 0,0));
    addVec(0, 0, 0,     0, 0, 0, 0, mk(0,0,0,0, 0,0, 8'h5A, 0,0));
    addVec(0, 0, 0,     0, 0, 0, 1, mk(0,0,0,0, 0,0, 8'h5A, 0,0));
    addVec(1, 0, 8'h01, 1, 1, 8'h02, 0, mk(1,0,0,S, S ? 8'h00 : 8'h01, 0, 8'h5A, 0,0));
    addVec(1, 0, 8'h01, 1, 1, 8'h02, 0, mk(0,0,0,S, S ? 8'h00 : 8'h01, 0, 8'h5A, 0,0));
    addVec(1, 0, 8'h01, 1, 1, 8'h02, 0, mk(0,1,0,S, S ? 8'h00 : 8'h01, S ? 8'h00 : 8'h02, 8'h5A, 0,0));
    addVec(1, 0, 8'h01, 0, 0, 0, 0, mk(0,0,0,S, S ? 8'h00 : 8'h01, S ? 8'h00 : 8'h02, 8'h5A, 0,0));
    addVec(1, 0, 8'h01, 0, 0, 0, 0, mk(1,0,0,S, S ? 8'h00 : 8'h01, S ? 8'h00 : 8'h02, 8'h5A, 0,0));
    addVec(0, 0, 0,     0, 0, 0, 0, mk(0,0,0,S, S ? 8'h00 : 8'h01, S ? 8'h00 : 8'h02, 8'h5A, 0,0));
    addVec(0, 0, 0,     0, 0, 0, 1, mk(0,0,0,0, 8'h01, 8'h02, 8'h5A, 0,0));
    addVec(1, 4, 8'h11, 0, 0, 0, 0, mk(1,0,0,S, 8'h01, 8'h02, 8'h5A, 0, S ? 8'h00 : 8'h11));
    addVec(0, 0, 0,     0, 0, 0, 0, mk(0,0,0,S, 8'h01, 8'h02, 8'h5A, 0, S ? 8'h00 : 8'h11));
    addVec(1, 4, 8'h22, 0, 0, 0, 1, mk(1,0,0,S, 8'h01, 8'h02, 8'h5A, 0, S ? 8'h11 : 8'h22));
    addVec(0, 0, 0,     0, 0, 0, 0, mk(0,0,0,S, 8'h01, 8'h02, 8'h5A, 0, S ? 8'h11 : 8'h22));
    addVec(0, 0, 0,     0, 0, 0, 1, mk(0,0,0,0, 8'h01, 8'h02, 8'h5A, 0, 8'h22));
    addVec(0, 0, 0,     1, 3, 8'h33, 0, mk(0,1,0,S, 8'h01, 8'h02, 8'h5A, S ? 8'h00 : 8'h33, 8'h22));
    addVec(0, 0, 0,     0, 0, 0, 0, mk(0,0,0,S, 8'h01, 8'h02, 8'h5A, S ? 8'h00 : 8'h33, 8'h22));
    addVec(0, 0, 0,     1, 3, 8'h3C, 0, mk(0,1,0,S, 8'h01, 8'h02, 8'h5A, S ? 8'h00 : 8'h3C, 8'h22));
    addVec(0, 0, 0,     0, 0, 0, 0, mk(0,0,0,S, 8'h01, 8'h02, 8'h5A, S ? 8'h00 : 8'h3C, 8'h22));
    addVec(0, 0, 0,     0, 0, 0, 1, mk(0,0,0,0, 8'h01, 8'h02, 8'h5A, 8'h3C, 8'h22));
    addVec(0, 0, 0,     1, 5, 8'hAA, 0, mk(0,1,1,0, 8'h01, 8'h02, 8'h5A, 8'h3C, 8'h22));
    addVec(0, 0, 0,     0, 0, 0, 0, mk(0,0,0,0, 8'h01, 8'h02, 8'h5A, 8'h3C, 8'h22));
    addVec(1, 7'h7C, 8'hEE, 0, 0, 0, 0, mk(1,0,1,0, 8'h01, 8'h02, 8'h5A, 8'h3C, 8'h22));
    addVec(0, 0, 0,     0, 0, 0, 0, mk(0,0,0,0, 8'h01, 8'h02, 8'h5A, 8'h3C, 8'h22));
    addVec(0, 0, 0,     0, 0, 0, 1, mk(0,0,0,0, 8'h01, 8'h02, 8'h5A, 8'h3C, 8'h22));

    rst_n = 1'b0;
    a_req = 0; a_addr = 0; a_data = 0;
    b_req = 0; b_addr = 0; b_data = 0;
    commit_strobe = 0;
    repeat (2) @(posedge m_clk);
    #1;
    checkOutput("reset_state", mk(0,0,0,0, 0,0,0,0,0));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut);
    end

    // A won last; a reset before the contest must drop the request and hand the next contest to A.
    a_req = 1; a_addr = 1; a_data = 8'h77;
    b_req = 1; b_addr = 2; b_data = 8'h88;
    commit_strobe = 0;
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_mid_clear", mk(0,0,0,0, 0,0,0,0,0));
    @(posedge m_clk);
    #1 checkOutput("rst_mid_hold", mk(0,0,0,0, 0,0,0,0,0));
    #2 rst_n = 1'b1;
    begin
      bit got = 1'b0;
      for (int c = 0; c < 4 && !got; c++) begin
        @(posedge m_clk);
        #1;
        if (a_gnt || b_gnt) got = 1'b1;
      end
    end
    checkOutput("rst_first_winner", mk(1,0,0,S, 0, S ? 8'h00 : 8'h77, 0,0,0));
    a_req = 0; b_req = 0;
    @(posedge m_clk);
    #1 checkOutput("rst_after_grant", mk(0,0,0,S, 0, S ? 8'h00 : 8'h77, 0,0,0));
    commit_strobe = 1;
    @(posedge m_clk);
    #1 checkOutput("rst_final_commit", mk(0,0,0,0, 0, 8'h77, 0,0,0));
    commit_strobe = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
